// File: rtl/div16_rr_sched.sv
// Two-requester round-robin front end sharing one 16/8 restoring divider.
// One operation in flight; tagged quotient/remainder/divide-by-zero response.
module div16_rr_sched #(
    parameter int NREQ = 2,
    parameter int ITER = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic [15:0]     req_a0,
    input  logic [7:0]      req_b0,
    input  logic [15:0]     req_a1,
    input  logic [7:0]      req_b1,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [15:0]     rsp_quot,
    output logic [15:0]     rsp_rem,
    output logic            rsp_dz,
    output logic            busy
);

    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic          rr_last;
    logic [15:0]   rem_q;
    logic [15:0]   quo_q;
    logic [15:0]   dvs_q;
    logic [CW-1:0] cnt;

    logic          gnt;
    logic [15:0]   sel_a;
    logic [7:0]    sel_b;
    logic [15:0]   rem_sh;
    logic          ge;
    logic [15:0]   rem_nx;
    logic [15:0]   quo_nx;

    always_comb begin
        gnt = 1'b0;
        if (&req_valid)
            gnt = ~rr_last;
        else if (req_valid[1])
            gnt = 1'b1;
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE)
            req_ready[gnt] = req_valid[gnt];
    end

    assign sel_a = gnt ? req_a1 : req_a0;
    assign sel_b = gnt ? req_b1 : req_b0;

    // One restoring step on the shifted {rem,quo} pair; rem stays below 2*divisor.
    assign rem_sh = {rem_q[14:0], quo_q[15]};
    assign ge     = (rem_sh >= dvs_q);
    assign rem_nx = ge ? (rem_sh - dvs_q) : rem_sh;
    assign quo_nx = {quo_q[14:0], ge};

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_last   <= 1'b1;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_quot  <= '0;
            rsp_rem   <= '0;
            rsp_dz    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        rr_last <= gnt;
                        rsp_id  <= gnt;
                        if (sel_b == 8'h00) begin
                            rsp_quot  <= '1;
                            rsp_rem   <= sel_a;
                            rsp_dz    <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            rem_q <= '0;
                            quo_q <= sel_a;
                            dvs_q <= {8'h00, sel_b};
                            cnt   <= '0;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1)) begin
                        rsp_quot  <= quo_nx;
                        rsp_rem   <= rem_nx;
                        rsp_dz    <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div16_rr_sched.sv
// Bench for div16_rr_sched: directed scenarios plus a randomized run checked
// against a queue-based model using plain division.
module tb_div16_rr_sched;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_a0;
    logic [7:0]  req_b0;
    logic [15:0] req_a1;
    logic [7:0]  req_b1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [15:0] rsp_quot;
    logic [15:0] rsp_rem;
    logic        rsp_dz;
    logic        busy;

    int total = 0;
    int bad   = 0;

    div16_rr_sched #(.NREQ(2), .ITER(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_quot(rsp_quot), .rsp_rem(rsp_rem), .rsp_dz(rsp_dz), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic wait_rsp(input int max, output int n);
        n = 0;
        while (!rsp_valid && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        tick(); tick();
        rst = 1'b0;
        settle();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL reset_rsp_id got=%b want=0", rsp_id); end
        total++; if (rsp_quot !== 16'h0) begin bad++; $display("FAIL reset_quot got=%h want=0", rsp_quot); end
        total++; if (rsp_rem !== 16'h0) begin bad++; $display("FAIL reset_rem got=%h want=0", rsp_rem); end
        total++; if (rsp_dz !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b want=0", rsp_dz); end
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%b want=00", req_ready); end
    endtask

    task automatic test_basic();
        int n;
        do_reset();
        req_a0 = 16'd1000; req_b0 = 8'd7; req_valid = 2'b01; rsp_ready = 1'b1;
        settle();
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL basic_ready got=%b want=01", req_ready); end
        tick();
        req_valid = 2'b00;
        wait_rsp(40, n);
        total++; if (n !== 16) begin bad++; $display("FAIL basic_latency got=%0d want=16", n); end
        total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL basic_id got=%b want=0", rsp_id); end
        total++; if (rsp_quot !== 16'd142) begin bad++; $display("FAIL basic_quot got=%0d want=142", rsp_quot); end
        total++; if (rsp_rem !== 16'd6) begin bad++; $display("FAIL basic_rem got=%0d want=6", rsp_rem); end
        total++; if (rsp_dz !== 1'b0) begin bad++; $display("FAIL basic_dz got=%b want=0", rsp_dz); end
        tick();
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_release got=%b%b want=00", rsp_valid, busy); end
    endtask

    task automatic test_contention();
        int n;
        do_reset();
        req_a0 = 16'd100; req_b0 = 8'd3; req_a1 = 16'd65535; req_b1 = 8'd255;
        req_valid = 2'b11; rsp_ready = 1'b1;
        settle();
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL cont_first_grant got=%b want=01", req_ready); end
        tick();
        req_valid = 2'b10;
        wait_rsp(40, n);
        total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0) begin bad++; $display("FAIL cont_rsp0 got=%b/%b want=1/0", rsp_valid, rsp_id); end
        total++; if (rsp_quot !== 16'd33 || rsp_rem !== 16'd1) begin bad++; $display("FAIL cont_val0 got=%0d/%0d want=33/1", rsp_quot, rsp_rem); end
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL cont_ready_done got=%b want=00", req_ready); end
        tick();
        total++; if (rsp_valid !== 1'b0 || req_ready !== 2'b10) begin bad++; $display("FAIL cont_second_grant got=%b/%b want=0/10", rsp_valid, req_ready); end
        tick();
        req_valid = 2'b00;
        wait_rsp(40, n);
        total++; if (n !== 16 || rsp_id !== 1'b1) begin bad++; $display("FAIL cont_rsp1 got=%0d/%b want=16/1", n, rsp_id); end
        total++; if (rsp_quot !== 16'd257 || rsp_rem !== 16'd0) begin bad++; $display("FAIL cont_val1 got=%0d/%0d want=257/0", rsp_quot, rsp_rem); end
        tick();
    endtask

    task automatic test_div_zero();
        do_reset();
        req_a1 = 16'h1234; req_b1 = 8'd0; req_valid = 2'b10; rsp_ready = 1'b1;
        settle();
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL dz_ready got=%b want=10", req_ready); end
        tick();
        req_valid = 2'b00;
        total++; if (rsp_valid !== 1'b1 || rsp_dz !== 1'b1 || rsp_id !== 1'b1) begin bad++; $display("FAIL dz_flags got=%b%b%b want=111", rsp_valid, rsp_dz, rsp_id); end
        total++; if (rsp_quot !== 16'hFFFF || rsp_rem !== 16'h1234) begin bad++; $display("FAIL dz_vals got=%h/%h want=ffff/1234", rsp_quot, rsp_rem); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL dz_release got=%b want=0", busy); end
    endtask

    task automatic test_backpressure();
        int n;
        int bad_hold;
        do_reset();
        req_a0 = 16'd50; req_b0 = 8'd8; req_valid = 2'b01; rsp_ready = 1'b0;
        tick();
        req_valid = 2'b00;
        wait_rsp(40, n);
        req_a1 = 16'd9; req_b1 = 8'd2; req_valid = 2'b10;
        settle();
        bad_hold = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b1 || rsp_quot !== 16'd6 || rsp_rem !== 16'd2 || req_ready !== 2'b00)
                bad_hold++;
            tick();
        end
        total++; if (bad_hold !== 0) begin bad++; $display("FAIL bp_hold got=%0d bad cycles want=0", bad_hold); end
        rsp_ready = 1'b1;
        tick();
        total++; if (rsp_valid !== 1'b0 || req_ready !== 2'b10) begin bad++; $display("FAIL bp_next_accept got=%b/%b want=0/10", rsp_valid, req_ready); end
        tick();
        req_valid = 2'b00;
        wait_rsp(40, n);
        total++; if (rsp_id !== 1'b1 || rsp_quot !== 16'd4 || rsp_rem !== 16'd1) begin bad++; $display("FAIL bp_second got=%b/%0d/%0d want=1/4/1", rsp_id, rsp_quot, rsp_rem); end
        tick();
    endtask

    task automatic test_reset_abort();
        int seen;
        do_reset();
        req_a1 = 16'd777; req_b1 = 8'd5; req_valid = 2'b10; rsp_ready = 1'b1;
        tick();
        req_valid = 2'b00;
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b1;
        tick();
        total++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL abort_state got=%b%b want=00", busy, rsp_valid); end
        total++; if (rsp_id !== 1'b0 || rsp_quot !== 16'h0) begin bad++; $display("FAIL abort_regs got=%b/%h want=0/0", rsp_id, rsp_quot); end
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rsp_valid === 1'b1) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_rsp got=%0d want=0", seen); end
        req_valid = 2'b11;
        settle();
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL abort_grant got=%b want=01", req_ready); end
        req_valid = 2'b00;
        settle();
    endtask

    typedef struct {
        logic        id;
        logic [15:0] a;
        logic [7:0]  b;
    } op_t;

    task automatic test_random();
        localparam int NOPS = 3000;
        op_t         q[$];
        op_t         op;
        logic        v[2];
        logic [15:0] ra[2];
        logic [7:0]  rb[2];
        logic        last;
        logic        exp_g;
        logic [1:0]  exp_rdy;
        logic        exp_rv;
        logic [15:0] eq;
        logic [15:0] er;
        int          age;
        int          acc_n;
        int          rsp_n;
        int          cyc;
        int          sel;
        do_reset();
        v[0] = 1'b0; v[1] = 1'b0; last = 1'b1; age = 0; acc_n = 0; rsp_n = 0; cyc = 0;
        while ((acc_n < NOPS || q.size() != 0) && cyc < 90000) begin
            for (int i = 0; i < 2; i++) begin
                if (!v[i] && acc_n < NOPS && $urandom_range(3) == 0) begin
                    v[i]  = 1'b1;
                    ra[i] = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
                    sel   = $urandom_range(7);
                    rb[i] = (sel == 0) ? 8'd0 : (sel == 1) ? 8'hFF : (sel == 2) ? 8'd1 : 8'($urandom);
                end else if (!v[i]) begin
                    ra[i] = 16'($urandom);
                    rb[i] = 8'($urandom);
                end
            end
            req_valid = {v[1], v[0]};
            req_a0 = ra[0]; req_b0 = rb[0]; req_a1 = ra[1]; req_b1 = rb[1];
            rsp_ready = ($urandom_range(3) != 0);
            settle();
            exp_g   = (v[0] && v[1]) ? ~last : v[1];
            exp_rdy = (q.size() == 0 && (v[0] || v[1])) ? (exp_g ? 2'b10 : 2'b01) : 2'b00;
            exp_rv  = (q.size() != 0) && (age >= ((q[0].b == 8'd0) ? 0 : 16));
            total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", cyc, req_ready, exp_rdy); end
            total++; if (rsp_valid !== exp_rv) begin bad++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b want=%b", cyc, rsp_valid, exp_rv); end
            if (exp_rv) begin
                op = q[0];
                eq = (op.b == 8'd0) ? 16'hFFFF : op.a / {8'h00, op.b};
                er = (op.b == 8'd0) ? op.a : op.a % {8'h00, op.b};
                total++;
                if (rsp_id !== op.id || rsp_quot !== eq || rsp_rem !== er || rsp_dz !== (op.b == 8'd0)) begin
                    bad++;
                    $display("FAIL rnd_rsp a=%0d b=%0d got=%b/%0d/%0d/%b want=%b/%0d/%0d/%b",
                             op.a, op.b, rsp_id, rsp_quot, rsp_rem, rsp_dz, op.id, eq, er, (op.b == 8'd0));
                end
            end
            @(posedge clk);
            if (exp_rv && rsp_ready) begin
                void'(q.pop_front());
                rsp_n++;
            end else if (q.size() != 0) begin
                age++;
            end
            if (exp_rdy != 2'b00) begin
                op.id = exp_g; op.a = ra[exp_g]; op.b = rb[exp_g];
                q.push_back(op);
                age = 0;
                v[exp_g] = 1'b0;
                last = exp_g;
                acc_n++;
            end
            #1;
            cyc++;
        end
        req_valid = 2'b00;
        total++; if (acc_n !== NOPS || rsp_n !== acc_n) begin bad++; $display("FAIL rnd_count got acc=%0d rsp=%0d want=%0d", acc_n, rsp_n, NOPS); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_contention();
        test_div_zero();
        test_backpressure();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
